// File: rtl/sbc_bus_encoder.sv
// Syndrome-based, transition-minimising bus encoder.
// Each 6-bit data beat is the target syndrome of the 13-bit bus word. The
// encoder flips the minimum-weight set of wires that moves the current bus
// syndrome onto the new data, so wire toggles equal the weight of the coset
// leader. Saturating word/toggle statistics are kept alongside.

// Minimum-weight coset leader lookup for the 6x13 parity-check matrix H.
// Ties are broken by searching weight 1, then 2, then 3, in ascending column
// order. Every syndrome has a leader of weight 3 or less. The unit-column
// fallback is only a safe default that still produces the correct syndrome.
module coset_leader_lut (
  input  logic [5:0]  syndrome,
  output logic [12:0] leader
);
  localparam logic [5:0] H_COL [0:12] = '{
    6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3C,
    6'h33, 6'h2A, 6'h15, 6'h1E, 6'h27, 6'h36
  };

  logic found_s;

  // Search for the lowest-weight column set whose XOR equals the syndrome.
  always_comb begin
    leader  = {7'h00, syndrome};
    found_s = 1'b0;
    if (syndrome == 6'h00) begin
      leader  = 13'h0000;
      found_s = 1'b1;
    end else begin
      found_s = 1'b0;
    end
    for (int i = 0; i < 13; i++) begin
      if (!found_s && (H_COL[i] == syndrome)) begin
        leader    = 13'h0000;
        leader[i] = 1'b1;
        found_s   = 1'b1;
      end
    end
    for (int i = 0; i < 13; i++) begin
      for (int j = i + 1; j < 13; j++) begin
        if (!found_s && ((H_COL[i] ^ H_COL[j]) == syndrome)) begin
          leader    = 13'h0000;
          leader[i] = 1'b1;
          leader[j] = 1'b1;
          found_s   = 1'b1;
        end
      end
    end
    for (int i = 0; i < 13; i++) begin
      for (int j = i + 1; j < 13; j++) begin
        for (int k = j + 1; k < 13; k++) begin
          if (!found_s && ((H_COL[i] ^ H_COL[j] ^ H_COL[k]) == syndrome)) begin
            leader    = 13'h0000;
            leader[i] = 1'b1;
            leader[j] = 1'b1;
            leader[k] = 1'b1;
            found_s   = 1'b1;
          end
        end
      end
    end
  end
endmodule

module sbc_bus_encoder #(
  parameter logic [12:0] RESET_BUS = 13'h0000,
  parameter int          CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [12:0]      bus_out,
  output logic [3:0]       out_toggles,
  input  logic             stats_clr,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_toggles
);
  localparam int SUM_W = CNT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [5:0] H_COL [0:12] = '{
    6'h01, 6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h3C,
    6'h33, 6'h2A, 6'h15, 6'h1E, 6'h27, 6'h36
  };

  // Syndrome of a bus word: XOR of the H columns selected by its set bits.
  function automatic logic [5:0] synd(input logic [12:0] v);
    logic [5:0] acc;
    acc = 6'h00;
    for (int j = 0; j < 13; j++) begin
      acc = acc ^ (v[j] ? H_COL[j] : 6'h00);
    end
    return acc;
  endfunction

  // Number of set bits in a 13-bit word (0..13).
  function automatic logic [3:0] popcount13(input logic [12:0] v);
    logic [3:0] cnt;
    cnt = 4'd0;
    for (int j = 0; j < 13; j++) begin
      cnt = cnt + {3'b000, v[j]};
    end
    return cnt;
  endfunction

  logic [12:0]      bus_r;
  logic             out_valid_r;
  logic [3:0]       out_toggles_r;
  logic [CNT_W-1:0] stat_words_r;
  logic [CNT_W-1:0] stat_toggles_r;

  logic [5:0]       syndrome_s;
  logic [12:0]      leader_s;
  logic [3:0]       tog_s;
  logic             accept_s;
  logic [SUM_W-1:0] tog_sum_s;

  coset_leader_lut u_lut (
    .syndrome (syndrome_s),
    .leader   (leader_s)
  );

  // Encode path: syndrome difference, leader weight and handshake.
  // Reset blocks the handshake so no beat is consumed in a reset cycle.
  always_comb begin
    syndrome_s = in_data ^ synd(bus_r);
    tog_s      = popcount13(leader_s);
    in_ready   = !rst && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready;
    tog_sum_s  = {1'b0, stat_toggles_r} + SUM_W'(tog_s);
  end

  // Output register: new bus word on accept, drop valid once consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus_r         <= RESET_BUS;
      out_valid_r   <= 1'b0;
      out_toggles_r <= 4'd0;
    end else if (accept_s) begin
      bus_r         <= bus_r ^ leader_s;
      out_valid_r   <= 1'b1;
      out_toggles_r <= tog_s;
    end else if (out_valid_r && out_ready) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  // Saturating statistics; a clear in an accept cycle counts that beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_words_r   <= '0;
      stat_toggles_r <= '0;
    end else if (stats_clr) begin
      stat_words_r   <= accept_s ? CNT_W'(1) : '0;
      stat_toggles_r <= accept_s ? CNT_W'(tog_s) : '0;
    end else if (accept_s) begin
      stat_words_r   <= (stat_words_r == CNT_MAX) ? CNT_MAX : stat_words_r + CNT_W'(1);
      stat_toggles_r <= tog_sum_s[CNT_W] ? CNT_MAX : tog_sum_s[CNT_W-1:0];
    end else begin
      stat_words_r   <= stat_words_r;
      stat_toggles_r <= stat_toggles_r;
    end
  end

  assign bus_out      = bus_r;
  assign out_valid    = out_valid_r;
  assign out_toggles  = out_toggles_r;
  assign stat_words   = stat_words_r;
  assign stat_toggles = stat_toggles_r;
endmodule
